garegga_gp9001_bridge: RTL and testbench

//  CPU-side initiator for the GP9001 op interface of garegga_gcu.
//  - Decodes 68000 accesses to the GP9001 window into single one-hot ops.
//  - Holds GP9001CS until the GCU acknowledges, then returns read data.
//  - Completes the CPU cycle with CPU_DTACK.
//  - Sits between the main-CPU address decoder and garegga_video.

---
 rtl/garegga_gp9001_bridge.sv | 178 +++++++++++++++++
 tb/tb_garegga_gp9001_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/garegga_gp9001_bridge.sv
`default_nettype none
// ============================================================================
// Module  : garegga_gp9001_bridge
// Brief   : 68000-side initiator turning GP9001 window accesses into GCU ops.
// Revision: 1.0 - initial release
// ============================================================================
module garegga_gp9001_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_CS,
    input  logic        CPU_RNW,
    input  logic [2:0]  CPU_ADDR,
    input  logic [15:0] CPU_DIN,
    output logic [15:0] CPU_DOUT,
    output logic        CPU_DTACK,
    output logic        GP9001CS,
    input  logic        GP9001ACK,
    output logic [15:0] GP9001DIN,
    input  logic [15:0] GP9001DOUT,
    output logic        GP9001_OP_SET_RAM_PTR,
    output logic        GP9001_OP_WRITE_RAM,
    output logic        GP9001_OP_READ_RAM_H,
    output logic        GP9001_OP_READ_RAM_L,
    output logic        GP9001_OP_SELECT_REG,
    output logic        GP9001_OP_WRITE_REG,
    output logic        BUSY,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // One-hot op vector bit positions
    localparam int c_OP_SET_PTR = 0;
    localparam int c_OP_WR_RAM  = 1;
    localparam int c_OP_RD_H    = 2;
    localparam int c_OP_RD_L    = 3;
    localparam int c_OP_SEL_REG = 4;
    localparam int c_OP_WR_REG  = 5;
    localparam logic [TW-1:0] c_CNT_LIMIT = TW'(TIMEOUT_CYCLES);

    state_t        r_state, w_state_nx;
    logic          r_cs_d;
    logic          r_rnw, w_rnw_nx;
    logic [TW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic          r_gcs, w_gcs_nx;
    logic [5:0]    r_op, w_op_nx, w_dec_op;
    logic [15:0]   r_gdin, w_gdin_nx;
    logic [15:0]   r_dout, w_dout_nx;
    logic          r_dtack, w_dtack_nx;
    logic          r_toerr, w_toerr_nx;
    logic          w_start;

    assign w_start   = CPU_CS & ~r_cs_d;
    assign w_cnt_inc = r_cnt + TW'(1);

    // Unsupported reads decode to no op and complete without touching the GCU
    always_comb begin
        w_dec_op = '0;
        if (!CPU_RNW) begin
            case (CPU_ADDR[2:1])
                2'd0:    w_dec_op[c_OP_SET_PTR] = 1'b1;
                2'd1:    w_dec_op[c_OP_WR_RAM]  = 1'b1;
                2'd2:    w_dec_op[c_OP_SEL_REG] = 1'b1;
                default: w_dec_op[c_OP_WR_REG]  = 1'b1;
            endcase
        end else if (CPU_ADDR == 3'd2) begin
            w_dec_op[c_OP_RD_H] = 1'b1;
        end else if (CPU_ADDR == 3'd3) begin
            w_dec_op[c_OP_RD_L] = 1'b1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_rnw_nx   = r_rnw;
        w_cnt_nx   = r_cnt;
        w_gcs_nx   = r_gcs;
        w_op_nx    = r_op;
        w_gdin_nx  = r_gdin;
        w_dout_nx  = r_dout;
        w_dtack_nx = r_dtack;
        w_toerr_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_rnw_nx  = CPU_RNW;
                    w_gdin_nx = CPU_DIN;
                    w_cnt_nx  = '0;
                    if (w_dec_op != '0) begin
                        w_state_nx = S_REQ;
                        w_gcs_nx   = 1'b1;
                        w_op_nx    = w_dec_op;
                    end else begin
                        w_state_nx = S_DONE;
                        w_dout_nx  = 16'hFFFF;
                    end
                end
            end
            S_REQ: w_state_nx = S_WAIT;
            S_WAIT: begin
                w_cnt_nx = w_cnt_inc;
                // ACK is tested first so a same-cycle timeout loses
                if (GP9001ACK) begin
                    if (r_rnw) w_dout_nx = GP9001DOUT;
                    w_gcs_nx   = 1'b0;
                    w_op_nx    = '0;
                    w_dtack_nx = 1'b1;
                    w_state_nx = S_DONE;
                end else if (w_cnt_inc == c_CNT_LIMIT) begin
                    w_dout_nx  = 16'hFFFF;
                    w_gcs_nx   = 1'b0;
                    w_op_nx    = '0;
                    w_dtack_nx = 1'b1;
                    w_toerr_nx = 1'b1;
                    w_state_nx = S_DONE;
                end
            end
            default: begin
                // Entered without DTACK only from a no-op read; raise it first
                if (!r_dtack) begin
                    w_dtack_nx = 1'b1;
                end else if (!CPU_CS) begin
                    w_dtack_nx = 1'b0;
                    w_state_nx = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cs_d  <= 1'b1;
            r_rnw   <= 1'b0;
            r_cnt   <= '0;
            r_gcs   <= 1'b0;
            r_op    <= '0;
            r_gdin  <= '0;
            r_dout  <= '0;
            r_dtack <= 1'b0;
            r_toerr <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cs_d  <= CPU_CS;
            r_rnw   <= w_rnw_nx;
            r_cnt   <= w_cnt_nx;
            r_gcs   <= w_gcs_nx;
            r_op    <= w_op_nx;
            r_gdin  <= w_gdin_nx;
            r_dout  <= w_dout_nx;
            r_dtack <= w_dtack_nx;
            r_toerr <= w_toerr_nx;
        end
    end

    assign CPU_DOUT              = r_dout;
    assign CPU_DTACK             = r_dtack;
    assign GP9001CS              = r_gcs;
    assign GP9001DIN             = r_gdin;
    assign GP9001_OP_SET_RAM_PTR = r_op[c_OP_SET_PTR];
    assign GP9001_OP_WRITE_RAM   = r_op[c_OP_WR_RAM];
    assign GP9001_OP_READ_RAM_H  = r_op[c_OP_RD_H];
    assign GP9001_OP_READ_RAM_L  = r_op[c_OP_RD_L];
    assign GP9001_OP_SELECT_REG  = r_op[c_OP_SEL_REG];
    assign GP9001_OP_WRITE_REG   = r_op[c_OP_WR_REG];
    assign BUSY                  = (r_state != S_IDLE);
    assign TIMEOUT_ERR           = r_toerr;

endmodule
`default_nettype wire

// File: tb/tb_garegga_gp9001_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_garegga_gp9001_bridge
// Brief   : Scoreboard bench for the GP9001 CPU-side bridge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_garegga_gp9001_bridge;

    localparam int TO = 255;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CPU_CS = 1'b0, CPU_RNW = 1'b0, GP9001ACK = 1'b0;
    logic [2:0]  CPU_ADDR = '0;
    logic [15:0] CPU_DIN = '0, GP9001DOUT = '0;
    logic [15:0] CPU_DOUT, GP9001DIN;
    logic        CPU_DTACK, GP9001CS, BUSY, TIMEOUT_ERR;
    logic        f_set, f_wram, f_rh, f_rl, f_sel, f_wreg;
    logic [5:0]  flags;
    assign flags = {f_wreg, f_sel, f_rl, f_rh, f_wram, f_set};

    garegga_gp9001_bridge #(.TIMEOUT_CYCLES(TO), .TW(8)) dut (
        .CLK(CLK), .RESET(RESET), .CPU_CS(CPU_CS), .CPU_RNW(CPU_RNW),
        .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT),
        .CPU_DTACK(CPU_DTACK), .GP9001CS(GP9001CS), .GP9001ACK(GP9001ACK),
        .GP9001DIN(GP9001DIN), .GP9001DOUT(GP9001DOUT),
        .GP9001_OP_SET_RAM_PTR(f_set), .GP9001_OP_WRITE_RAM(f_wram),
        .GP9001_OP_READ_RAM_H(f_rh), .GP9001_OP_READ_RAM_L(f_rl),
        .GP9001_OP_SELECT_REG(f_sel), .GP9001_OP_WRITE_REG(f_wreg),
        .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  op;
        logic [15:0] gdin;
        int          lat;
        logic [15:0] dout;
        int          toerr;
        int          gcs;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, failures = 0;
    logic [15:0] model_dout = '0;
    logic [5:0]  o_op;
    logic [15:0] o_gdin, o_dout;
    int          o_lat, o_toerr, o_gcs, o_bad, o_dtlen;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Independent reference of decode, latency and read-back data
    function automatic exp_t model(input logic rnw, input logic [2:0] addr,
                                   input logic [15:0] din, input int k,
                                   input logic [15:0] gd);
        exp_t e;
        e.op = '0;
        if (!rnw) begin
            case (addr[2:1])
                2'd0: e.op = 6'b000001;
                2'd1: e.op = 6'b000010;
                2'd2: e.op = 6'b010000;
                default: e.op = 6'b100000;
            endcase
        end else if (addr == 3'd2) e.op = 6'b000100;
        else if (addr == 3'd3) e.op = 6'b001000;
        e.gdin = din;
        e.toerr = 0;
        if (e.op == '0) begin
            e.lat = 2; e.dout = 16'hFFFF; e.gcs = 0;
        end else if (k > 0 && k <= TO) begin
            e.lat = k + 2; e.dout = rnw ? gd : model_dout; e.gcs = k + 1;
        end else begin
            e.lat = TO + 2; e.dout = 16'hFFFF; e.toerr = 1; e.gcs = TO + 1;
        end
        return e;
    endfunction

    // CPU + GCU driver; k = WAIT cycle carrying ACK (0 = never)
    task automatic drive(input logic rnw, input logic [2:0] addr, input logic [15:0] din,
                         input int k, input logic [15:0] gd, input bit drop_early,
                         input int hold);
        bit seen = 0;
        int held = 0;
        o_op = '0; o_gdin = '0; o_dout = '0;
        o_lat = 0; o_toerr = 0; o_gcs = 0; o_bad = 0; o_dtlen = 0;
        CPU_RNW = rnw; CPU_ADDR = addr; CPU_DIN = din; GP9001DOUT = gd; CPU_CS = 1'b1;
        for (int t = 1; t <= 400; t++) begin
            tick();
            if (t == 1) begin
                o_op = flags; o_gdin = GP9001DIN;
                CPU_DIN = ~din; CPU_ADDR = addr ^ 3'b111; CPU_RNW = ~rnw;
            end
            if (GP9001CS) begin
                o_gcs++;
                if (flags !== o_op) o_bad++;
            end else if (flags !== 6'b0) o_bad++;
            if ($countones(flags) > 1) o_bad++;
            if (TIMEOUT_ERR) o_toerr++;
            if (CPU_DTACK) begin
                o_dtlen++;
                if (!seen) begin seen = 1; o_lat = t; o_dout = CPU_DOUT; end
            end
            GP9001ACK = (k > 0 && t == k + 1);
            if (drop_early && t == 2) CPU_CS = 1'b0;
            if (seen) begin
                if (held >= hold) CPU_CS = 1'b0;
                else held++;
            end
            if (seen && !CPU_DTACK) break;
        end
        GP9001ACK = 1'b0;
        CPU_CS = 1'b0;
    endtask

    task automatic test_reset();
        int stray = 0;
        RESET = 1'b1; CPU_CS = 1'b1;
        repeat (3) tick();
        checks++;
        if ({CPU_DOUT, CPU_DTACK, GP9001CS, GP9001DIN, flags, BUSY, TIMEOUT_ERR} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got dout=%h dtack=%b gcs=%b gdin=%h flags=%b busy=%b toerr=%b want all 0",
                     CPU_DOUT, CPU_DTACK, GP9001CS, GP9001DIN, flags, BUSY, TIMEOUT_ERR);
        end
        RESET = 1'b0;
        repeat (6) begin tick(); if (GP9001CS || BUSY || CPU_DTACK) stray++; end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL cs_high_at_reset_release got %0d active cycles want 0", stray);
        end
        CPU_CS = 1'b0;
        repeat (2) tick();
        model_dout = '0;
    endtask

    task automatic test_writes();
        logic [2:0]  a[6] = '{3'd4, 3'd6, 3'd0, 3'd2, 3'd1, 3'd7};
        logic [15:0] d[6] = '{16'h0003, 16'h1234, 16'h0100, 16'hBEEF, 16'h0F0F, 16'h8001};
        int          kk[6] = '{2, 2, 1, 3, 1, 4};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            e = model(1'b0, a[i], d[i], kk[i], 16'h0);
            sb.push_back(e);
            model_dout = e.dout;
            drive(1'b0, a[i], d[i], kk[i], 16'hDEAD, 1'b0, 0);
            e = sb.pop_front();
            checks++; if (o_op !== e.op) begin failures++; $display("FAIL wr%0d_op got %b want %b", i, o_op, e.op); end
            checks++; if (o_gdin !== e.gdin) begin failures++; $display("FAIL wr%0d_gdin got %h want %h", i, o_gdin, e.gdin); end
            checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL wr%0d_dtack_latency got %0d want %0d", i, o_lat, e.lat); end
            checks++; if (o_dout !== e.dout) begin failures++; $display("FAIL wr%0d_dout got %h want %h", i, o_dout, e.dout); end
            checks++; if (o_gcs !== e.gcs || o_bad !== 0) begin failures++; $display("FAIL wr%0d_gcs got cycles=%0d bad=%0d want %0d/0", i, o_gcs, o_bad, e.gcs); end
        end
    endtask

    task automatic test_reads();
        logic [2:0]  a[5] = '{3'd2, 3'd3, 3'd5, 3'd3, 3'd0};
        int          kk[5] = '{5, 2, 0, 3, 0};
        logic [15:0] g[5] = '{16'hA5A5, 16'h5A3C, 16'h1111, 16'h1357, 16'h2222};
        bit          de[5] = '{0, 0, 0, 1, 0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            e = model(1'b1, a[i], 16'h0000, kk[i], g[i]);
            sb.push_back(e);
            model_dout = e.dout;
            drive(1'b1, a[i], 16'h0000, kk[i], g[i], de[i], 0);
            e = sb.pop_front();
            checks++; if (o_op !== e.op) begin failures++; $display("FAIL rd%0d_op got %b want %b", i, o_op, e.op); end
            checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL rd%0d_dtack_latency got %0d want %0d", i, o_lat, e.lat); end
            checks++; if (o_dout !== e.dout) begin failures++; $display("FAIL rd%0d_dout got %h want %h", i, o_dout, e.dout); end
            checks++; if (o_gcs !== e.gcs || o_bad !== 0) begin failures++; $display("FAIL rd%0d_gcs got cycles=%0d bad=%0d want %0d/0", i, o_gcs, o_bad, e.gcs); end
            checks++; if (o_dtlen !== 1) begin failures++; $display("FAIL rd%0d_dtack_len got %0d want 1", i, o_dtlen); end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        e = model(1'b0, 3'd6, 16'h7777, 0, 16'h0);
        sb.push_back(e);
        model_dout = e.dout;
        drive(1'b0, 3'd6, 16'h7777, 0, 16'h0, 1'b0, 0);
        e = sb.pop_front();
        checks++; if (o_gcs !== e.gcs) begin failures++; $display("FAIL to_gcs_cycles got %0d want %0d", o_gcs, e.gcs); end
        checks++; if (o_toerr !== e.toerr) begin failures++; $display("FAIL to_err_pulses got %0d want %0d", o_toerr, e.toerr); end
        checks++; if (o_lat !== e.lat) begin failures++; $display("FAIL to_dtack_latency got %0d want %0d", o_lat, e.lat); end
        checks++; if (o_dout !== e.dout) begin failures++; $display("FAIL to_dout got %h want %h", o_dout, e.dout); end
    endtask

    task automatic test_hold_cs();
        exp_t e;
        e = model(1'b0, 3'd5, 16'h4242, 1, 16'h0);
        sb.push_back(e);
        model_dout = e.dout;
        drive(1'b0, 3'd5, 16'h4242, 1, 16'h0, 1'b0, 20);
        tick();
        e = sb.pop_front();
        checks++; if (o_gcs !== e.gcs || o_op !== e.op) begin failures++; $display("FAIL hold_second_op got cycles=%0d op=%b want %0d/%b", o_gcs, o_op, e.gcs, e.op); end
        checks++; if (o_dtlen !== 21) begin failures++; $display("FAIL hold_dtack_len got %0d want 21", o_dtlen); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL hold_busy got %b want 0", BUSY); end
    endtask

    task automatic test_reset_mid();
        CPU_RNW = 1'b0; CPU_ADDR = 3'd6; CPU_DIN = 16'h5555; CPU_CS = 1'b1;
        repeat (3) tick();
        checks++;
        if (!(GP9001CS === 1'b1 && BUSY === 1'b1)) begin
            failures++; $display("FAIL mid_pre got gcs=%b busy=%b want 1/1", GP9001CS, BUSY);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if ({GP9001CS, flags, CPU_DTACK, BUSY, CPU_DOUT} !== '0) begin
            failures++;
            $display("FAIL mid_reset got gcs=%b flags=%b dtack=%b busy=%b dout=%h want 0",
                     GP9001CS, flags, CPU_DTACK, BUSY, CPU_DOUT);
        end
        RESET = 1'b0; CPU_CS = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_writes();
        test_reads();
        test_timeout();
        test_hold_cs();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
